// File: rtl/cycle_sequencer.sv
// ============================================================================
// cycle_sequencer : four-phase instruction cycle FSM (T0..T3) with PC,
//                   single-step mode, halt request and branch handling.
// Revision 1.0
// ============================================================================
`default_nettype none

module cycle_sequencer #(
   parameter logic [4:0] PC_MAX = 5'd31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       step_mode,
   input  logic       halt_req,
   input  logic [3:0] instr_opcode,
   input  logic [4:0] jump_addr,
   input  logic       zero_flag,
   input  logic       carry_flag,
   output logic [1:0] timing_signal,
   output logic [4:0] pc,
   output logic       mem_rd,
   output logic       ir_load,
   output logic       alu_en,
   output logic       acc_we,
   output logic       busy,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [3:0] OP_JZ  = 4'b1100;
   localparam logic [3:0] OP_JC  = 4'b1101;
   localparam logic [3:0] OP_JMP = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   state_t     state;
   logic [3:0] op;
   logic       halt_pending;

   logic       jump_taken;
   logic       halt_exit;

   function automatic logic is_alu_op(input logic [3:0] o);
      return (o >= 4'd1) && (o <= 4'd11);
   endfunction

   // Output vector {timing[1:0], mem_rd, ir_load, alu_en, acc_we, busy, halted}
   // for the state being entered, so every strobe is a flop.
   function automatic logic [7:0] decode_outs(input state_t st, input logic [3:0] o);
      logic [7:0] v;
      v = 8'b0;
      case (st)
         S_T0:    v = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         S_T1:    v = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
         S_T2:    v = {2'b10, 1'b0, 1'b0, is_alu_op(o), 1'b0, 1'b1, 1'b0};
         S_T3:    v = {2'b11, 1'b0, 1'b0, 1'b0, is_alu_op(o), 1'b1, 1'b0};
         S_HALT:  v = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         default: v = 8'b0;
      endcase
      return v;
   endfunction

   assign jump_taken = ((op == OP_JZ) && zero_flag) ||
                       ((op == OP_JC) && carry_flag) ||
                       (op == OP_JMP);

   // A same-cycle halt_req counts as pending, so a pulse in T3 stops at this exit.
   assign halt_exit  = (op == OP_HLT) || halt_pending || halt_req ||
                       (!jump_taken && (pc == PC_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         pc            <= 5'd0;
         op            <= 4'd0;
         halt_pending  <= 1'b0;
         timing_signal <= 2'b00;
         mem_rd        <= 1'b0;
         ir_load       <= 1'b0;
         alu_en        <= 1'b0;
         acc_we        <= 1'b0;
         busy          <= 1'b0;
         halted        <= 1'b0;
      end else begin
         if (halt_req && (state != S_HALT))
            halt_pending <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_T0;
                  {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                     <= decode_outs(S_T0, op);
               end
            end
            S_T0: begin
               op    <= instr_opcode;
               state <= S_T1;
               {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                  <= decode_outs(S_T1, instr_opcode);
            end
            S_T1: begin
               state <= S_T2;
               {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                  <= decode_outs(S_T2, op);
            end
            S_T2: begin
               state <= S_T3;
               {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                  <= decode_outs(S_T3, op);
            end
            S_T3: begin
               if (jump_taken)
                  pc <= jump_addr;
               else if ((op != OP_HLT) && (pc < PC_MAX))
                  pc <= pc + 5'd1;

               if (halt_exit) begin
                  state        <= S_HALT;
                  halt_pending <= 1'b0;
                  {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                     <= decode_outs(S_HALT, op);
               end else if (step_mode) begin
                  state <= S_IDLE;
                  {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                     <= decode_outs(S_IDLE, op);
               end else begin
                  state <= S_T0;
                  {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted}
                     <= decode_outs(S_T0, op);
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
               {timing_signal, mem_rd, ir_load, alu_en, acc_we, busy, halted} <= 8'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
// ============================================================================
// tb_cycle_sequencer : directed self-checking bench for cycle_sequencer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cycle_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       step_mode;
   logic       halt_req;
   logic [3:0] instr_opcode;
   logic [4:0] jump_addr;
   logic       zero_flag;
   logic       carry_flag;
   logic [1:0] timing_signal;
   logic [4:0] pc;
   logic       mem_rd;
   logic       ir_load;
   logic       alu_en;
   logic       acc_we;
   logic       busy;
   logic       halted;

   int checks;
   int failures;

   cycle_sequencer #(.PC_MAX(5'd31)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .step_mode     (step_mode),
      .halt_req      (halt_req),
      .instr_opcode  (instr_opcode),
      .jump_addr     (jump_addr),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .timing_signal (timing_signal),
      .pc            (pc),
      .mem_rd        (mem_rd),
      .ir_load       (ir_load),
      .alu_en        (alu_en),
      .acc_we        (acc_we),
      .busy          (busy),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      start    = 1'b0;
      halt_req = 1'b0;
      tick();
      tick();
      check_value("rst_pc", pc, 0);
      check_value("rst_timing", timing_signal, 0);
      check_value("rst_strobes", {mem_rd, ir_load, alu_en, acc_we}, 0);
      check_value("rst_busy_halted", {busy, halted}, 0);
      reset = 1'b0;
      tick();
   endtask

   // One step-mode instruction; hr_phase 1/3 pulses halt_req while in T1/T3.
   task automatic run_instr(input logic [3:0] op, input logic [4:0] ja, input logic z,
                            input logic c, input int hr_phase,
                            input logic [4:0] exp_pc, input logic exp_halted);
      logic alu_exp;
      alu_exp      = (op >= 4'd1) && (op <= 4'd11);
      instr_opcode = op;
      jump_addr    = ja;
      zero_flag    = z;
      carry_flag   = c;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check_value("t0_timing", timing_signal, 0);
      check_value("t0_mrd_irl_busy", {mem_rd, ir_load, busy}, 3'b111);
      tick();
      if (hr_phase == 1) halt_req = 1'b1;
      check_value("t1_timing", timing_signal, 1);
      check_value("t1_strobes", {mem_rd, ir_load, alu_en, acc_we}, 0);
      tick();
      halt_req = 1'b0;
      check_value("t2_timing", timing_signal, 2);
      check_value("t2_alu_en", alu_en, alu_exp);
      tick();
      if (hr_phase == 3) halt_req = 1'b1;
      check_value("t3_timing", timing_signal, 3);
      check_value("t3_acc_we", {acc_we, alu_en}, {alu_exp, 1'b0});
      tick();
      halt_req = 1'b0;
      check_value("end_pc", pc, exp_pc);
      check_value("end_halted", halted, exp_halted);
      check_value("end_busy", busy, 0);
      check_value("end_timing", timing_signal, 0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      start        = 1'b0;
      step_mode    = 1'b1;
      halt_req     = 1'b0;
      instr_opcode = 4'd0;
      jump_addr    = 5'd0;
      zero_flag    = 1'b0;
      carry_flag   = 1'b0;

      // Step mode: ALU op, branches taken / not taken, NOP.
      apply_reset();
      run_instr(4'b0001, 5'd0,  1'b0, 1'b0, 0, 5'd1,  1'b0);
      run_instr(4'b1100, 5'd20, 1'b1, 1'b0, 0, 5'd20, 1'b0);
      run_instr(4'b1100, 5'd2,  1'b0, 1'b0, 0, 5'd21, 1'b0);
      run_instr(4'b1101, 5'd4,  1'b0, 1'b1, 0, 5'd4,  1'b0);
      run_instr(4'b1101, 5'd9,  1'b1, 1'b0, 0, 5'd5,  1'b0);
      run_instr(4'b0000, 5'd0,  1'b0, 1'b0, 0, 5'd6,  1'b0);
      run_instr(4'b1011, 5'd0,  1'b0, 1'b0, 0, 5'd7,  1'b0);
      // halt_req in T1 with JMP: jump applied and halted.
      run_instr(4'b1110, 5'd7,  1'b0, 1'b0, 1, 5'd7,  1'b1);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      check_value("halt_ignores_start", {halted, busy}, 2'b10);
      check_value("halt_pc_hold", pc, 7);

      // HLT at pc=3.
      apply_reset();
      run_instr(4'b0000, 5'd0, 1'b0, 1'b0, 0, 5'd1, 1'b0);
      run_instr(4'b0000, 5'd0, 1'b0, 1'b0, 0, 5'd2, 1'b0);
      run_instr(4'b0000, 5'd0, 1'b0, 1'b0, 0, 5'd3, 1'b0);
      run_instr(4'b1111, 5'd0, 1'b0, 1'b0, 0, 5'd3, 1'b1);
      start     = 1'b1;
      step_mode = 1'b0;
      halt_req  = 1'b1;
      tick();
      tick();
      tick();
      start     = 1'b0;
      halt_req  = 1'b0;
      step_mode = 1'b1;
      check_value("hlt_stays", {halted, busy, timing_signal}, 4'b1000);
      check_value("hlt_pc", pc, 3);

      // halt_req in T3 takes effect at that exit.
      apply_reset();
      run_instr(4'b0000, 5'd0, 1'b0, 1'b0, 3, 5'd1, 1'b1);

      // Jump to PC_MAX does not halt; the instruction there then runs and halts.
      apply_reset();
      run_instr(4'b1110, 5'd31, 1'b0, 1'b0, 0, 5'd31, 1'b0);
      run_instr(4'b0000, 5'd0,  1'b0, 1'b0, 0, 5'd31, 1'b1);

      // Asynchronous reset during T2 at pc=9.
      apply_reset();
      run_instr(4'b1110, 5'd9, 1'b0, 1'b0, 0, 5'd9, 1'b0);
      instr_opcode = 4'b0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_value("pre_abort_timing", timing_signal, 2);
      check_value("pre_abort_pc", pc, 9);
      #2;
      reset = 1'b1;
      #1;
      check_value("abort_pc", pc, 0);
      check_value("abort_timing", timing_signal, 0);
      check_value("abort_outs", {alu_en, busy, halted}, 0);
      tick();
      reset = 1'b0;
      tick();
      check_value("abort_idle", {busy, timing_signal, pc}, 0);

      // Continuous run of NOPs: 0..31 then halt holding 31.
      apply_reset();
      instr_opcode = 4'b0000;
      step_mode    = 1'b0;
      start        = 1'b1;
      for (int k = 0; k < 32; k++) begin
         for (int ph = 0; ph < 4; ph++) begin
            tick();
            check_value("run_timing", timing_signal, ph);
            check_value("run_pc", pc, k);
         end
      end
      tick();
      start = 1'b0;
      check_value("run_end_halted", {halted, busy}, 2'b10);
      check_value("run_end_pc", pc, 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
